// File: rtl/button_event_decoder_if.sv
// Button event bundle: debounced switch level in, registered event pulses and held level out.
interface button_event_decoder_if;
  logic i_Switch;
  logic o_Press;
  logic o_Release;
  logic o_Long_Press;
  logic o_Repeat;
  logic o_Held;

  modport master (
    input  i_Switch,
    output o_Press, o_Release, o_Long_Press, o_Repeat, o_Held
  );

  modport slave (
    output i_Switch,
    input  o_Press, o_Release, o_Long_Press, o_Repeat, o_Held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/long-press/repeat
// pulses plus a registered held level; all outputs come straight from flops.
module button_event_decoder #(
  parameter int unsigned c_LONG_LIMIT   = 12500000,
  parameter int unsigned c_REPEAT_LIMIT = 2500000,
  parameter bit          c_REPEAT_EN    = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  button_event_decoder_if.master bus
);

  localparam int unsigned CNT_W = $clog2(c_LONG_LIMIT);
  localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(c_LONG_LIMIT - 1);
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(c_REPEAT_LIMIT - 1);

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    HELD         = 2'd2,
    REPEAT       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  // State, hold counter and output flops; reset starts in WAIT_RELEASE so a
  // button held through reset stays silent until it is let go.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= WAIT_RELEASE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  // Next-state and next-output; release is checked first so it wins over
  // a long-press or repeat that falls due on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      WAIT_RELEASE: begin
        if (!bus.i_Switch) state_d = IDLE;
      end
      IDLE: begin
        if (bus.i_Switch) begin
          state_d = HELD;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!bus.i_Switch) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == LONG_MAX) begin
          state_d = REPEAT;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!bus.i_Switch) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (!c_REPEAT_EN) begin
          cnt_d = '0;
        end else if (cnt_q == REPEAT_MAX) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_RELEASE;
    endcase

    held_d = (state_d == HELD) || (state_d == REPEAT);
  end

  assign bus.o_Press      = press_q;
  assign bus.o_Release    = release_q;
  assign bus.o_Long_Press = long_q;
  assign bus.o_Repeat     = repeat_q;
  assign bus.o_Held       = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: a hold-time model pushes expected
// output vectors per edge, a negedge monitor pops and compares both variants.
module tb_button_event_decoder;

  localparam int unsigned LONG = 8;
  localparam int unsigned REP  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic sw;

  always #5 clk = ~clk;

  button_event_decoder_if bif1 ();
  button_event_decoder_if bif0 ();
  assign bif1.i_Switch = sw;
  assign bif0.i_Switch = sw;

  button_event_decoder #(.c_LONG_LIMIT(LONG), .c_REPEAT_LIMIT(REP), .c_REPEAT_EN(1'b1)) dut_en1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(bif1)
  );
  button_event_decoder #(.c_LONG_LIMIT(LONG), .c_REPEAT_LIMIT(REP), .c_REPEAT_EN(1'b0)) dut_en0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(bif0)
  );

  // {press, release, long, repeat, held}
  wire [4:0] act1 = {bif1.o_Press, bif1.o_Release, bif1.o_Long_Press, bif1.o_Repeat, bif1.o_Held};
  wire [4:0] act0 = {bif0.o_Press, bif0.o_Release, bif0.o_Long_Press, bif0.o_Repeat, bif0.o_Held};

  typedef struct packed {
    logic [4:0] en1;
    logic [4:0] en0;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got p/r/l/rp/h=%b expected %b", nm, $time, act, exp);
    end
  endtask

  // Reference model: counts edges since the press edge and derives events from t.
  bit armed   = 1'b0;
  bit holding = 1'b0;
  int t       = 0;

  always @(posedge clk) begin
    logic p, r, l, rp;
    p = 1'b0; r = 1'b0; l = 1'b0; rp = 1'b0;
    if (!rst_n) begin
      armed   = 1'b0;
      holding = 1'b0;
      t       = 0;
    end else if (!armed) begin
      if (!sw) armed = 1'b1;
    end else if (!holding) begin
      if (sw) begin
        holding = 1'b1;
        t       = 0;
        p       = 1'b1;
      end
    end else if (!sw) begin
      holding = 1'b0;
      r       = 1'b1;
    end else begin
      t++;
      if (t == int'(LONG)) l = 1'b1;
      else if (t > int'(LONG) && ((t - int'(LONG)) % int'(REP)) == 0) rp = 1'b1;
    end
    q.push_back('{en1: {p, r, l, rp, holding}, en0: {p, r, l, 1'b0, holding}});
  end

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (!rst_n) e = '0;
      check("out_en1", act1, e.en1);
      check("out_en0", act0, e.en0);
    end
  end

  task automatic drive(input logic v, input int n);
    sw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset(input logic v, input int n);
    sw    = v;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    sw    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Short hold, 20-cycle hold, release on long edge, release on repeat edge.
    drive(1'b0, 2); drive(1'b1, 4);  drive(1'b0, 5);
    drive(1'b1, 20); drive(1'b0, 5);
    drive(1'b1, 8);  drive(1'b0, 4);
    drive(1'b1, 11); drive(1'b0, 4); drive(1'b1, 5); drive(1'b0, 3);

    // Button held across reset release.
    pulse_reset(1'b1, 2);
    drive(1'b1, 5); drive(1'b0, 1); drive(1'b1, 4); drive(1'b0, 3);

    // Reset asserted mid-repeat clears outputs before the next edge.
    drive(1'b1, 12);
    rst_n = 1'b0;
    #1;
    check("async_rst_en1", act1, 5'b0);
    check("async_rst_en0", act0, 5'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 6); drive(1'b0, 3);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 40) == 0)
        pulse_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      else
        drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    end

    drive(1'b0, 3);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued expectations, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the debounced, active-high level from the switch debouncer into single-cycle button events: press, release, long-press and auto-repeat, plus a registered held level. It sits directly downstream of the debouncer and drives game and menu logic that needs edge events rather than levels. All outputs are registered.

## Interface
- c_LONG_LIMIT, default 12500000: hold cycles from press to long-press event (500 ms at 25 MHz); must be ≥ 2.
- c_REPEAT_LIMIT, default 2500000: cycles between auto-repeat events (100 ms at 25 MHz); must be ≥ 2 and ≤ c_LONG_LIMIT.
- c_REPEAT_EN, default 1: 1 enables auto-repeat pulses; 0 suppresses them.

Ports:
- i_Clk  in  1  system clock; the only clock.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_Switch  in  1  debounced switch level, 1 = pressed; already synchronous to i_Clk.
- o_Press  out  1  one-cycle pulse on press.
- o_Release  out  1  one-cycle pulse on release.
- o_Long_Press  out  1  one-cycle pulse when the hold reaches c_LONG_LIMIT.
- o_Repeat  out  1  one-cycle pulse every c_REPEAT_LIMIT cycles after the long-press.
- o_Held  out  1  registered level, 1 while in HELD or REPEAT.

## Operation
- One hold counter, width $clog2(c_LONG_LIMIT); unsigned; never wraps, because it is cleared before reaching c_LONG_LIMIT.
- States: WAIT_RELEASE, IDLE, HELD, REPEAT. The reset state is WAIT_RELEASE.
- WAIT_RELEASE:
  - i_Switch = 0 moves to IDLE with no outputs.
  - i_Switch = 1 stays in WAIT_RELEASE.
  - A button held through reset therefore produces no events until it is released and pressed again.
- IDLE:
  - i_Switch = 1 moves to HELD; o_Press = 1; o_Held = 1; counter cleared to 0.
- HELD:
  - i_Switch = 0: go to IDLE; o_Release = 1; o_Held = 0; counter cleared.
  - Else if counter == c_LONG_LIMIT−1: go to REPEAT; o_Long_Press = 1; counter cleared.
  - Else counter increments.
- REPEAT:
  - i_Switch = 0: go to IDLE; o_Release = 1; o_Held = 0; counter cleared.
  - Else if c_REPEAT_EN = 1 and counter == c_REPEAT_LIMIT−1: o_Repeat = 1; counter cleared.
  - Else counter increments. With c_REPEAT_EN = 0 the counter holds at 0.
- Pulse outputs are 0 in every cycle not listed above.
- Boundary rules:
  - Release beats long-press or repeat on the same edge: only o_Release fires.
  - At most one pulse output is high in any cycle.
  - o_Press and o_Release always alternate; o_Long_Press fires at most once per press.

## Timing
- Reset (i_Rst_L low, asynchronous): all outputs 0, counter 0, state WAIT_RELEASE. Reset asserted mid-hold drops o_Held immediately, with no o_Release.
- Let edge k be the first clock edge at which i_Switch samples 1 while in IDLE.
  - o_Press is high for the cycle after edge k; o_Held goes high after edge k.
  - o_Long_Press is high for the cycle after edge k+c_LONG_LIMIT.
  - o_Repeat is high for the cycle after edge k+c_LONG_LIMIT+m·c_REPEAT_LIMIT, for m ≥ 1.
- Let edge j be the first edge sampling 0 while in HELD or REPEAT: o_Release is high for the cycle after edge j, and o_Held goes low after edge j.
- Minimum press is 1 cycle: press at edge k, release at edge k+1 gives back-to-back o_Press then o_Release pulses.
- Latency from input to output is 1 cycle. There is no combinational path from i_Switch to any output.

## Test plan
Benches use c_LONG_LIMIT = 8, c_REPEAT_LIMIT = 3.
- Reset with i_Switch = 0, then hold i_Switch = 1 from edge k = 2 through edge 5, then 0: o_Press after edge 2, o_Release after edge 6, o_Held high after edges 2..5, no long-press.
- Hold from edge k = 2 for 20 cycles: o_Long_Press after edge 10, o_Repeat after edges 13, 16 and 19, o_Release after edge 22. Never two pulses in one cycle.
- Release on edge k+8, the edge where long-press would fire: only o_Release, no o_Long_Press.
- Release on the repeat-due edge k+11: only o_Release. Then press again at k+15: o_Press, with timing restarting from zero.
- Hold i_Switch = 1 across reset release: no events. Drop to 0 for 1 cycle, then raise: o_Press one cycle after the rising sample.
- Assert i_Rst_L low mid-REPEAT: all outputs 0 asynchronously, before the next clock. Keep i_Switch = 1 after reset release: no o_Release, no o_Press.
- Repeat the 20-cycle hold with c_REPEAT_EN = 0: o_Long_Press only, no o_Repeat, o_Release after edge 22.
